// File: rtl/ef_apb_cmd_master_if.sv
// Command/response port plus APB3 bus bundled for ef_apb_cmd_master.
// The master modport is the initiator's view. The slave modport is the environment's view.
interface ef_apb_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/ef_apb_cmd_master.sv
// APB3 initiator: runs one command at a time as a SETUP/ACCESS transfer.
// It returns the read data, the slave error and the timeout status on a response port.
module ef_apb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  ef_apb_cmd_master_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_paddr;
  logic          r_pwrite;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_tout;
  logic [CW-1:0] r_cnt;
  logic          w_tout_hit;

  // The count of stalled ACCESS cycles reaches TIMEOUT on this edge.
  assign w_tout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.cmd_valid)                w_next = S_SETUP;
      S_SETUP:                                    w_next = S_ACCESS;
      S_ACCESS: if (bus.PREADY || w_tout_hit)     w_next = S_RESP;
      S_RESP:   if (bus.rsp_ready)                w_next = S_IDLE;
      default:                                    w_next = S_IDLE;
    endcase
  end

  // Handshake and select strobes decode only from state, so reset drops PSEL at once.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    case (r_state)
      S_IDLE:   bus.cmd_ready = 1'b1;
      S_SETUP:  bus.PSEL      = 1'b1;
      S_ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
      end
      S_RESP:   bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_tout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_paddr  <= bus.cmd_addr;
            r_pwrite <= bus.cmd_write;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
          end
        end
        S_SETUP: r_cnt <= '0;
        S_ACCESS: begin
          if (bus.PREADY) begin
            r_rdata <= r_pwrite ? '0 : bus.PRDATA;
            r_err   <= bus.PSLVERR;
            r_tout  <= 1'b0;
          end else if (w_tout_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tout  <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PADDR       = r_paddr;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.rsp_timeout = r_tout;

endmodule

// File: tb/tb_ef_apb_cmd_master.sv
// Directed bench for ef_apb_cmd_master (TIMEOUT=8). A scoreboard queue holds expected responses.
// A negedge monitor pops that queue on each response handshake.
module tb_ef_apb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic PCLK;
  logic PRESET;

  ef_apb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

  ef_apb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_exp;
  rsp_t bp_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          s_wait = 0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;
  logic        s_err_early = 1'b0;
  int          acc_n = 0;

  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_pwdata;
  int          cur_eacc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic samp();
    @(negedge PCLK);
  endtask

  function automatic logic [127:0] rst_vec();
    return {25'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
            bus.PADDR, bus.PWRITE, bus.PSEL, bus.PENABLE, bus.PWDATA};
  endfunction

  // APB slave: PREADY rises on ACCESS cycle number s_wait (counting from 0). Junk data and s_err_early are driven while it waits.
  always @(posedge PCLK) begin
    #1;
    if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
      if (acc_n == s_wait) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = s_rdata;
        bus.PSLVERR = s_err;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hDEAD_BEEF;
        bus.PSLVERR = s_err_early;
      end
      acc_n++;
    end else begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      acc_n = 0;
    end
  end

  // Response monitor: the handshake completes at the following rising edge.
  always @(negedge PCLK) begin
    if (PRESET === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_fields", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, mon_exp);
      end
    end
  end

  task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int wait_n, input logic [31:0] srd, input logic serr,
                         input logic searly, input logic [31:0] erd, input logic eerr,
                         input logic eto, input int eacc);
    tick();
    s_wait        = wait_n;
    s_rdata       = srd;
    s_err         = serr;
    s_err_early   = searly;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    cur_wr        = wr;
    cur_addr      = addr;
    cur_pwdata    = wr ? wdata : 32'h0;
    cur_eacc      = eacc;
    exp_q.push_back({erd, eerr, eto});
  endtask

  task automatic accept_and_run(input int stop_after, output int wait_acc);
    int  n;
    int  acc;
    int  unstable;
    bit  got;
    n = 0; acc = 0; unstable = 0; got = 0;
    samp();
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      samp();
      n++;
    end
    wait_acc = n;
    check("cmd_accept", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    samp();
    check("setup_phase", {bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
          {1'b0, 1'b1, 1'b0, cur_wr, cur_addr, cur_pwdata});
    n = 0;
    while (n < 300) begin
      tick();
      samp();
      n++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        acc++;
        if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {cur_wr, cur_addr, cur_pwdata}) unstable++;
      end
      if (stop_after > 0 && acc == stop_after) return;
    end
    check("rsp_valid_seen", got, 1);
    check("access_cycles", acc, cur_eacc);
    check("access_hold", unstable, 0);
    check("resp_bus_idle", {bus.PSEL, bus.PENABLE, bus.cmd_ready}, 0);
  endtask

  task automatic release_rsp(input int bp);
    for (int i = 0; i < bp; i++) begin
      tick();
      samp();
      check("rsp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
            {1'b1, 1'b0, exp_q[0]});
    end
    tick();
    bus.rsp_ready = 1'b1;
    samp();
    tick();
    bus.rsp_ready = 1'b0;
    samp();
    check("back_to_idle", {bus.cmd_ready, bus.rsp_valid, bus.PSEL}, {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_rv;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    #3;
    check("reset_values", rst_vec(), {25'd0, 1'b1, 102'd0});
    tick();
    tick();
    PRESET = 1'b0;

    // Zero-wait write.
    present(1'b1, 32'h04, 32'hA5, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    accept_and_run(0, w);
    release_rsp(0);

    // Read with 3 wait states. The non-zero cmd_wdata must not reach PWDATA.
    present(1'b0, 32'h00, 32'h5555_5555, 3, 32'hAB, 1'b0, 1'b0, 32'hAB, 1'b0, 1'b0, 4);
    accept_and_run(0, w);
    release_rsp(0);

    // Slave error on a write. PSLVERR is also high while PREADY is low.
    present(1'b1, 32'h08, 32'h1234, 2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 3);
    accept_and_run(0, w);
    release_rsp(0);

    // PSLVERR is high only while PREADY is low, so it must be ignored.
    present(1'b0, 32'h0C, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 3);
    accept_and_run(0, w);
    release_rsp(0);

    // Read that completes with an error still returns PRDATA.
    present(1'b0, 32'h14, 32'h0, 0, 32'h77, 1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 1);
    accept_and_run(0, w);
    release_rsp(0);

    // Timeout: PREADY stuck low. Abort after exactly 8 ACCESS cycles.
    present(1'b0, 32'h30, 32'h0, 1000, 32'h99, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8);
    accept_and_run(0, w);
    release_rsp(2);

    // The next command after the timeout completes normally.
    present(1'b0, 32'h34, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2);
    accept_and_run(0, w);
    release_rsp(0);

    // Boundary: PREADY arrives on the last allowed ACCESS cycle and wins over the timeout.
    present(1'b1, 32'h38, 32'hFFFF_0000, 7, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8);
    accept_and_run(0, w);
    release_rsp(0);

    // Back-pressure with a second command waiting.
    present(1'b1, 32'h10, 32'h11, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    accept_and_run(0, w);
    bp_exp = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 0) present(1'b0, 32'h18, 32'h0, 0, 32'h5A5A, 1'b0, 1'b0, 32'h5A5A, 1'b0, 1'b0, 1);
      else        tick();
      samp();
      check("bp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
            {1'b1, 1'b0, bp_exp});
    end
    tick();
    bus.rsp_ready = 1'b1;
    samp();
    tick();
    bus.rsp_ready = 1'b0;
    accept_and_run(0, w);
    check("bp_next_accept_wait", w, 0);
    release_rsp(0);

    // Reset in the middle of a wait-stated read.
    present(1'b0, 32'h20, 32'h0, 10, 32'h42, 1'b0, 1'b0, 32'h42, 1'b0, 1'b0, 11);
    accept_and_run(2, w);
    #2;
    PRESET = 1'b1;
    #1;
    check("reset_async_psel", {bus.PSEL, bus.PENABLE}, 0);
    check("reset_mid_values", rst_vec(), {25'd0, 1'b1, 102'd0});
    exp_q.delete();
    tick();
    tick();
    PRESET = 1'b0;
    n_rv = 0;
    for (int i = 0; i < 4; i++) begin
      samp();
      if (bus.rsp_valid !== 1'b0) n_rv++;
      tick();
    end
    check("no_rsp_after_reset", n_rv, 0);

    // First command after reset behaves as the zero-wait write.
    present(1'b1, 32'h04, 32'hA5, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    accept_and_run(0, w);
    release_rsp(0);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
